pipe_skid_stage: RTL

//  Generic parametrised pipeline-stage register with valid/ready handshake and a 2-entry skid buffer.

---
 rtl/pipe_pkg.sv | 17 +
 rtl/sat_counter.sv | 24 ++
 rtl/pipe_skid_stage.sv | 120 ++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and constants for pipeline stage registers
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_BUSY,
        ST_FULL
    } pipe_state_e;

    localparam logic [31:0] RV_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } if_id_t;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter, cleared only by reset
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] r_count;

    // Count up on inc and stick at all-ones instead of wrapping
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (inc && (r_count != '1)) begin
            r_count <= r_count + W'(1);
        end
    end

    assign count = r_count;

endmodule

// File: rtl/pipe_skid_stage.sv
// rtl/pipe_skid_stage.sv - valid/ready pipeline register with 2-entry skid buffer
module pipe_skid_stage
    import pipe_pkg::*;
#(
    parameter int                DATA_W    = 64,
    parameter logic [DATA_W-1:0] FLUSH_VAL = '0,
    parameter int                CNT_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  bubble_cnt
);

    pipe_state_e       r_state;
    pipe_state_e       w_state_nxt;
    logic [DATA_W-1:0] r_main;
    logic [DATA_W-1:0] r_skid;
    logic [DATA_W-1:0] w_main_nxt;
    logic [DATA_W-1:0] w_skid_nxt;
    logic              r_in_ready;
    logic              w_out_valid;
    logic              w_in_fire;
    logic              w_out_fire;
    logic              w_bubble;

    // Handshakes only look at flops on our side, so no in_* <-> out_* comb path exists
    assign w_out_valid = (r_state != ST_EMPTY);
    assign w_in_fire   = in_valid & r_in_ready;
    assign w_out_fire  = w_out_valid & out_ready;
    assign w_bubble    = out_ready & ~w_out_valid;

    // Next-state and data-register selection; flush overrides every transition
    always_comb begin
        w_state_nxt = r_state;
        w_main_nxt  = r_main;
        w_skid_nxt  = r_skid;
        if (flush) begin
            w_state_nxt = ST_EMPTY;
            w_main_nxt  = FLUSH_VAL;
            w_skid_nxt  = FLUSH_VAL;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_in_fire) begin
                        w_main_nxt  = in_data;
                        w_state_nxt = ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (w_in_fire && w_out_fire) begin
                        w_main_nxt = in_data;
                    end else if (w_in_fire) begin
                        w_skid_nxt  = in_data;
                        w_state_nxt = ST_FULL;
                    end else if (w_out_fire) begin
                        // main keeps its stale payload; out_valid masks it
                        w_state_nxt = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    // in_ready is low here, so only the drain side can move
                    if (w_out_fire) begin
                        w_main_nxt  = r_skid;
                        w_state_nxt = ST_BUSY;
                    end
                end
                default: begin
                    w_state_nxt = ST_EMPTY;
                end
            endcase
        end
    end

    // State, payload registers and the registered in_ready
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_EMPTY;
            r_main     <= FLUSH_VAL;
            r_skid     <= FLUSH_VAL;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_main     <= w_main_nxt;
            r_skid     <= w_skid_nxt;
            r_in_ready <= (w_state_nxt != ST_FULL);
        end
    end

    // Occupancy decode from the state register
    always_comb begin
        occupancy = 2'd0;
        case (r_state)
            ST_BUSY: occupancy = 2'd1;
            ST_FULL: occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

    sat_counter #(
        .W(CNT_W)
    ) u_bubble_cnt (
        .clk  (clk),
        .reset(reset),
        .inc  (w_bubble),
        .count(bubble_cnt)
    );

    assign in_ready  = r_in_ready;
    assign out_valid = w_out_valid;
    assign out_data  = r_main;

endmodule
